stream_mux_rr: RTL and testbench

Packet-aware, registered N-to-1 stream multiplexer with valid/ready handshakes and selectable arbitration (round-robin or fixed priority). It is the sequential successor to the combinational 2/4/8-to-1 muxes in the common-components library. Typical use: merging several producer streams onto one shared downstream channel without splitting packets.

---
 rtl/stream_mux_pkg.sv | 16 +
 rtl/stream_mux_rr_if.sv | 31 +++
 rtl/stream_mux_rr_arbiter.sv | 43 ++++
 rtl/stream_mux_rr.sv | 131 +++++++++++++
 tb/tb_stream_mux_rr.sv | 291 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/stream_mux_pkg.sv
// Shared types for the stream_mux_rr block.
//   state_e     : packet FSM state (IDLE = free to arbitrate, LOCKED = mid-packet)
//   prio_mode_e : arbitration policy chosen by the prio_mode pin
package stream_mux_pkg;

    typedef enum logic {
        IDLE   = 1'b0,
        LOCKED = 1'b1
    } state_e;

    typedef enum logic {
        PRIO_RR    = 1'b0,
        PRIO_FIXED = 1'b1
    } prio_mode_e;

endpackage

// File: rtl/stream_mux_rr_if.sv
// Stream bundle for stream_mux_rr: NUM_CH upstream valid/ready/data/last
// channels plus the single merged downstream channel.
//   master : the environment side (drives upstream beats and out_ready)
//   slave  : the multiplexer side (drives in_ready and the out_* beat)
// Channel i data sits at in_data[i].
interface stream_mux_rr_if #(
    parameter int NUM_CH    = 4,
    parameter int DATAWIDTH = 8,
    parameter int CH_W      = $clog2(NUM_CH)
);
    logic [NUM_CH-1:0]                in_valid;
    logic [NUM_CH-1:0]                in_ready;
    logic [NUM_CH-1:0][DATAWIDTH-1:0] in_data;
    logic [NUM_CH-1:0]                in_last;

    logic                             out_valid;
    logic                             out_ready;
    logic [DATAWIDTH-1:0]             out_data;
    logic                             out_last;
    logic [CH_W-1:0]                  out_ch;

    modport master (
        output in_valid, in_data, in_last, out_ready,
        input  in_ready, out_valid, out_data, out_last, out_ch
    );

    modport slave (
        input  in_valid, in_data, in_last, out_ready,
        output in_ready, out_valid, out_data, out_last, out_ch
    );
endinterface

// File: rtl/stream_mux_rr_arbiter.sv
// rr_arbiter: purely combinational channel picker for stream_mux_rr.
//   i_req         : per-channel request (in_valid)
//   i_rr_ptr      : round-robin search start index
//   i_mode        : PRIO_RR searches upward from i_rr_ptr with wrap,
//                   PRIO_FIXED picks the lowest requesting index
//   o_grant       : winning channel index (0 when nothing requests)
//   o_grant_valid : at least one channel requests
module rr_arbiter
    import stream_mux_pkg::*;
#(
    parameter int NUM_CH = 4,
    parameter int CH_W   = $clog2(NUM_CH)
) (
    input  logic [NUM_CH-1:0] i_req,
    input  logic [CH_W-1:0]   i_rr_ptr,
    input  prio_mode_e        i_mode,
    output logic [CH_W-1:0]   o_grant,
    output logic              o_grant_valid
);

    int w_idx;

    always_comb begin
        // NOTE: every output gets a default before any branch so no path leaves it unassigned (no latch).
        o_grant       = '0;
        o_grant_valid = 1'b0;
        w_idx         = 0;
        // Scanning from the far end and overwriting leaves the first hit of the
        // upward search as the final value.
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            if (i_mode == PRIO_FIXED) begin
                w_idx = i;
            end else begin
                w_idx = (int'(i_rr_ptr) + i) % NUM_CH;
            end
            if (i_req[w_idx]) begin
                o_grant       = CH_W'(w_idx);
                o_grant_valid = 1'b1;
            end
        end
    end

endmodule

// File: rtl/stream_mux_rr.sv
// stream_mux_rr: packet-aware registered N-to-1 stream multiplexer.
//   clk, rst_n : clock (rising edge), asynchronous active-low reset
//   prio_mode  : 0 = round-robin, 1 = fixed priority (lowest index wins);
//                only looked at when choosing a new packet
//   busy       : high while a multi-beat packet holds the grant
//   bus        : upstream channels and the registered downstream beat
// A channel keeps the grant from its first beat until its last beat, so
// packets are never interleaved. Arbitration happens in the same cycle as the
// first beat, so back-to-back packets flow without a bubble.
module stream_mux_rr
    import stream_mux_pkg::*;
#(
    parameter int NUM_CH    = 4,
    parameter int DATAWIDTH = 8,
    parameter int CH_W      = $clog2(NUM_CH)
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           prio_mode,
    output logic           busy,
    stream_mux_rr_if.slave bus
);

    state_e               r_state;
    state_e               w_state_nxt;
    logic [CH_W-1:0]      r_grant;
    logic [CH_W-1:0]      r_rr_ptr;
    prio_mode_e           r_pkt_mode;
    prio_mode_e           w_mode;

    logic [CH_W-1:0]      w_arb_grant;
    logic                 w_arb_valid;
    logic [CH_W-1:0]      w_sel;
    logic                 w_sel_valid;
    logic                 w_can_load;
    logic                 w_xfer;
    logic                 w_xfer_last;
    logic [NUM_CH-1:0]    w_in_ready;

    logic                 r_out_valid;
    logic [DATAWIDTH-1:0] r_out_data;
    logic                 r_out_last;
    logic [CH_W-1:0]      r_out_ch;

    rr_arbiter #(
        .NUM_CH (NUM_CH),
        .CH_W   (CH_W)
    ) u_arb (
        .i_req         (bus.in_valid),
        .i_rr_ptr      (r_rr_ptr),
        .i_mode        (prio_mode_e'(prio_mode)),
        .o_grant       (w_arb_grant),
        .o_grant_valid (w_arb_valid)
    );

    // The policy that chose the current packet decides whether its last beat
    // advances rr_ptr; a mid-packet change of prio_mode must not affect it.
    assign w_mode = (r_state == IDLE) ? prio_mode_e'(prio_mode) : r_pkt_mode;

    always_comb begin
        w_can_load = !r_out_valid || bus.out_ready;

        w_sel       = w_arb_grant;
        w_sel_valid = w_arb_valid;
        if (r_state == LOCKED) begin
            // Held even when the owner drops in_valid: the output simply bubbles.
            w_sel       = r_grant;
            w_sel_valid = 1'b1;
        end

        w_in_ready = '0;
        if (rst_n && w_sel_valid) begin
            w_in_ready[w_sel] = w_can_load;
        end

        w_xfer      = w_in_ready[w_sel] && bus.in_valid[w_sel];
        w_xfer_last = bus.in_last[w_sel];

        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (w_xfer && !w_xfer_last) w_state_nxt = LOCKED;
            LOCKED:  if (w_xfer &&  w_xfer_last) w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_grant     <= '0;
            r_pkt_mode  <= PRIO_RR;
            r_rr_ptr    <= '0;
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_out_last  <= 1'b0;
            r_out_ch    <= '0;
        end else begin
            if (w_xfer) begin
                r_out_valid <= 1'b1;
                r_out_data  <= bus.in_data[w_sel];
                r_out_last  <= w_xfer_last;
                r_out_ch    <= w_sel;
                if (r_state == IDLE) begin
                    r_grant    <= w_sel;
                    r_pkt_mode <= w_mode;
                end
                if (w_xfer_last && w_mode == PRIO_RR) begin
                    r_rr_ptr <= (w_sel == CH_W'(NUM_CH - 1)) ? '0 : w_sel + CH_W'(1);
                end
            end else if (bus.out_ready) begin
                r_out_valid <= 1'b0;
            end
        end
    end

    assign bus.in_ready  = w_in_ready;
    assign bus.out_valid = r_out_valid;
    assign bus.out_data  = r_out_data;
    assign bus.out_last  = r_out_last;
    assign bus.out_ch    = r_out_ch;
    assign busy          = (r_state == LOCKED);

endmodule

// File: tb/tb_stream_mux_rr.sv
// Self-checking bench for stream_mux_rr. Per-channel source queues feed the
// upstream ports; the expected downstream order is pushed to a scoreboard
// queue as each scenario is set up and popped whenever a beat leaves the DUT.
module tb_stream_mux_rr;
    import stream_mux_pkg::*;

    localparam int NUM_CH    = 4;
    localparam int DATAWIDTH = 8;
    localparam int CH_W      = $clog2(NUM_CH);

    typedef struct packed {
        logic                 last;
        logic [DATAWIDTH-1:0] data;
    } beat_t;

    typedef struct packed {
        logic [CH_W-1:0]      ch;
        logic                 last;
        logic [DATAWIDTH-1:0] data;
    } exp_t;

    logic clk       = 1'b0;
    logic rst_n     = 1'b0;
    logic prio_mode = 1'b0;
    logic busy;

    beat_t             src_q [NUM_CH][$];
    exp_t              exp_q [$];
    logic [NUM_CH-1:0] ch_en = '0;
    int                n_checks = 0;
    int                n_errors = 0;
    int                cyc;

    stream_mux_rr_if #(.NUM_CH(NUM_CH), .DATAWIDTH(DATAWIDTH)) bus ();

    stream_mux_rr #(
        .NUM_CH    (NUM_CH),
        .DATAWIDTH (DATAWIDTH)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .prio_mode (prio_mode),
        .busy      (busy),
        .bus       (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, act, req);
        end
    endtask

    task automatic add_src(input int ch, input logic [DATAWIDTH-1:0] data, input logic last);
        beat_t b;
        b.data = data;
        b.last = last;
        src_q[ch].push_back(b);
    endtask

    task automatic expect_beat(input int ch, input logic [DATAWIDTH-1:0] data, input logic last);
        exp_t e;
        e.ch   = CH_W'(ch);
        e.data = data;
        e.last = last;
        exp_q.push_back(e);
    endtask

    task automatic drive();
        for (int c = 0; c < NUM_CH; c++) begin
            if (ch_en[c] && src_q[c].size() > 0) begin
                bus.in_valid[c] = 1'b1;
                bus.in_data[c]  = src_q[c][0].data;
                bus.in_last[c]  = src_q[c][0].last;
            end else begin
                bus.in_valid[c] = 1'b0;
                bus.in_data[c]  = '0;
                bus.in_last[c]  = 1'b0;
            end
        end
    endtask

    // One clock: sample handshakes at the falling edge, let the rising edge
    // commit them, then retire accepted source beats and re-drive.
    task automatic tick();
        logic [NUM_CH-1:0] fire;
        exp_t              got;
        exp_t              want;
        @(negedge clk);
        fire = bus.in_valid & bus.in_ready;
        if (bus.out_valid && bus.out_ready) begin
            got = {bus.out_ch, bus.out_last, bus.out_data};
            if (exp_q.size() == 0) begin
                check("beat_expected", 32'(exp_q.size()), 32'd1);
            end else begin
                want = exp_q.pop_front();
                check("out_beat", 32'(got), 32'(want));
            end
        end
        @(posedge clk);
        #1;
        for (int c = 0; c < NUM_CH; c++) begin
            if (fire[c] && src_q[c].size() > 0) void'(src_q[c].pop_front());
        end
        drive();
    endtask

    task automatic drain(input int budget, output int cycles);
        cycles = 0;
        while (exp_q.size() > 0 && cycles < budget) begin
            tick();
            cycles++;
        end
        if (exp_q.size() > 0) begin
            check("drain_timeout", 32'(exp_q.size()), 32'd0);
            exp_q.delete();
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        bus.out_ready = 1'b0;
        drive();
        repeat (3) @(posedge clk);
        #1;
        check("rst_out_valid", 32'(bus.out_valid), 32'd0);
        check("rst_busy",      32'(busy),          32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Reset mid-packet: first beat of ch2 sits in the output slot.
        add_src(2, 8'hA0, 1'b0);
        add_src(2, 8'hA1, 1'b0);
        add_src(2, 8'hA2, 1'b1);
        ch_en = 4'b0100;
        drive();
        tick();
        #1;
        check("pre_rst_busy",      32'(busy),          32'd1);
        check("pre_rst_out_valid", 32'(bus.out_valid), 32'd1);
        check("pre_rst_out_data",  32'(bus.out_data),  32'hA0);
        rst_n = 1'b0;
        #2;
        check("mid_rst_out_valid", 32'(bus.out_valid), 32'd0);
        check("mid_rst_out_data",  32'(bus.out_data),  32'd0);
        check("mid_rst_in_ready",  32'(bus.in_ready),  32'd0);
        check("mid_rst_busy",      32'(busy),          32'd0);
        for (int c = 0; c < NUM_CH; c++) src_q[c].delete();
        ch_en = '0;
        drive();
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Round-robin fairness after reset: ch0 wins the first tie, no gaps.
        prio_mode     = 1'b0;
        bus.out_ready = 1'b1;
        for (int k = 0; k < 2; k++) begin
            for (int c = 0; c < NUM_CH; c++) begin
                add_src(c, 8'(c * 16 + k), 1'b1);
                expect_beat(c, 8'(c * 16 + k), 1'b1);
            end
        end
        ch_en = '1;
        drive();
        drain(50, cyc);
        check("rr_no_gap_cycles", 32'(cyc), 32'd9);

        // Packet lock in round-robin: ch2 holds the grant, then ch3, then ch0.
        add_src(2, 8'hB0, 1'b0);
        add_src(2, 8'hB1, 1'b0);
        add_src(2, 8'hB2, 1'b1);
        add_src(0, 8'h05, 1'b1);
        add_src(3, 8'h35, 1'b1);
        expect_beat(2, 8'hB0, 1'b0);
        expect_beat(2, 8'hB1, 1'b0);
        expect_beat(2, 8'hB2, 1'b1);
        expect_beat(3, 8'h35, 1'b1);
        expect_beat(0, 8'h05, 1'b1);
        ch_en = 4'b0100;
        drive();
        tick();
        ch_en = 4'b1101;
        drive();
        #1;
        check("lock_busy",         32'(busy),                     32'd1);
        check("lock_others_ready", 32'(bus.in_ready & 4'b1011), 32'd0);
        drain(50, cyc);

        // Packet lock in fixed priority: after ch2, ch0 beats ch3.
        prio_mode = 1'b1;
        add_src(2, 8'hC0, 1'b0);
        add_src(2, 8'hC1, 1'b0);
        add_src(2, 8'hC2, 1'b1);
        add_src(0, 8'h06, 1'b1);
        add_src(3, 8'h36, 1'b1);
        expect_beat(2, 8'hC0, 1'b0);
        expect_beat(2, 8'hC1, 1'b0);
        expect_beat(2, 8'hC2, 1'b1);
        expect_beat(0, 8'h06, 1'b1);
        expect_beat(3, 8'h36, 1'b1);
        ch_en = 4'b0100;
        drive();
        tick();
        ch_en = 4'b1101;
        drive();
        drain(50, cyc);

        // Fixed priority starvation: ch1 served until empty, only then ch3.
        for (int k = 0; k < 6; k++) begin
            add_src(1, 8'(8'h10 + k), 1'b1);
            add_src(3, 8'(8'h30 + k), 1'b1);
        end
        for (int k = 0; k < 6; k++) expect_beat(1, 8'(8'h10 + k), 1'b1);
        for (int k = 0; k < 6; k++) expect_beat(3, 8'(8'h30 + k), 1'b1);
        ch_en = 4'b1010;
        drive();
        drain(50, cyc);

        // Backpressure: slot held stable, nothing accepted, then full rate.
        prio_mode = 1'b0;
        for (int k = 0; k < 4; k++) begin
            add_src(1, 8'(8'hD0 + k), k == 3);
            expect_beat(1, 8'(8'hD0 + k), k == 3);
        end
        ch_en = 4'b0010;
        drive();
        tick();
        bus.out_ready = 1'b0;
        for (int k = 0; k < 5; k++) begin
            tick();
            #1;
            check("bp_out_valid", 32'(bus.out_valid), 32'd1);
            check("bp_out_data",  32'(bus.out_data),  32'hD0);
            check("bp_in_ready",  32'(bus.in_ready),  32'd0);
        end
        bus.out_ready = 1'b1;
        drain(20, cyc);
        check("bp_resume_cycles", 32'(cyc), 32'd4);

        // Mode switch and valid drop mid-packet: ch1 keeps the grant; the next
        // packet is chosen by fixed priority (ch0 before ch2).
        for (int k = 0; k < 4; k++) begin
            add_src(1, 8'(8'hE0 + k), k == 3);
            expect_beat(1, 8'(8'hE0 + k), k == 3);
        end
        add_src(0, 8'h07, 1'b1);
        add_src(2, 8'h27, 1'b1);
        expect_beat(0, 8'h07, 1'b1);
        expect_beat(2, 8'h27, 1'b1);
        ch_en = 4'b0010;
        drive();
        tick();
        prio_mode = 1'b1;
        ch_en     = 4'b0111;
        drive();
        tick();
        ch_en = 4'b0101;
        drive();
        for (int k = 0; k < 2; k++) begin
            tick();
            #1;
            check("drop_busy",         32'(busy),                     32'd1);
            check("drop_others_ready", 32'(bus.in_ready & 4'b0101), 32'd0);
        end
        check("drop_bubble", 32'(bus.out_valid), 32'd0);
        ch_en = 4'b0111;
        drive();
        drain(30, cyc);

        tick();
        #1;
        check("final_out_valid", 32'(bus.out_valid), 32'd0);
        check("final_busy",      32'(busy),          32'd0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
